// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage register file.
// Decodes the W-stage instruction into a write enable and destination, commits
// write-back data into the GPR array, serves two D-stage read ports with a
// same-cycle W->D bypass, and counts retired (non-nop) instructions.
// Optional feature: define WB_TRACE_EN to print each committed GPR write
// in simulation; the default build has no trace and is fully synthesizable.
module wb_regfile #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      w_pc,
    input  logic [31:0]      w_instr,
    input  logic [DW-1:0]    w_data,
    input  logic [AW-1:0]    d_rs_addr,
    input  logic [AW-1:0]    d_rt_addr,
    output logic [DW-1:0]    d_rs_data,
    output logic [DW-1:0]    d_rt_data,
    output logic             w_we,
    output logic [AW-1:0]    w_dst,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int NREG = 2 ** AW;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;

    logic [DW-1:0]    r_gpr [NREG];
    logic [CNT_W-1:0] r_retire_cnt;

    logic [5:0]       w_op;
    logic [5:0]       w_funct;
    logic             w_commit;

    assign w_op     = w_instr[31:26];
    assign w_funct  = w_instr[5:0];
    // A write only lands in the array when it targets a real register.
    assign w_commit = w_we && (w_dst != '0);

    // Decode the W-stage instruction into write enable and destination register.
    always_comb begin
        w_we  = 1'b0;
        w_dst = '0;
        if (w_op == OP_RTYPE && (w_funct == FN_ADD || w_funct == FN_SUB)) begin
            w_we  = 1'b1;
            w_dst = AW'(w_instr[15:11]);
        end else if (w_op == OP_ORI || w_op == OP_LW || w_op == OP_LUI) begin
            w_we  = 1'b1;
            w_dst = AW'(w_instr[20:16]);
        end else if (w_op == OP_JAL) begin
            w_we  = 1'b1;
            w_dst = AW'(5'd31);
        end
    end

    // Commit write-back data into the GPR array; reset clears every entry and drops the write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_gpr[i] <= '0;
            end
        end else if (w_commit) begin
            r_gpr[w_dst] <= w_data;
        end
    end

    // Count every non-nop instruction reaching W; wraps naturally at the counter width.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retire_cnt <= '0;
        end else if (w_instr != 32'd0) begin
            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
        end
    end

    assign retire_cnt = r_retire_cnt;

    // Read ports: $0 is hard-wired to zero, a same-cycle W write bypasses the array.
    assign d_rs_data = (d_rs_addr == '0)                ? '0     :
                       (w_we && (w_dst == d_rs_addr))   ? w_data :
                                                          r_gpr[d_rs_addr];
    assign d_rt_data = (d_rt_addr == '0)                ? '0     :
                       (w_we && (w_dst == d_rt_addr))   ? w_data :
                                                          r_gpr[d_rt_addr];

`ifdef WB_TRACE_EN
    // Simulation trace of every write that actually lands in the array.
    always_ff @(posedge clk) begin
        if (!reset && w_commit) begin
            $display("@%h: $%d <= %h", w_pc, w_dst, w_data);
        end
    end
`else
    // The PC is only needed for the trace.
    logic w_unused_pc;
    assign w_unused_pc = ^w_pc;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed cases followed by randomized
// instruction streams, compared against an architectural register-file model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] w_pc;
    logic [31:0] w_instr;
    logic [31:0] w_data;
    logic [4:0]  d_rs_addr;
    logic [4:0]  d_rt_addr;
    logic [31:0] d_rs_data, d_rt_data;
    logic        w_we;
    logic [4:0]  w_dst;
    logic [31:0] retire_cnt;

    logic [31:0] d4_rs_data, d4_rt_data;
    logic        w4_we;
    logic [4:0]  w4_dst;
    logic [3:0]  retire_cnt4;

    int n_cmp = 0;
    int n_err = 0;

    // Architectural model state
    logic [31:0] m_gpr [32];
    logic [31:0] m_cnt;
    logic [31:0] pc;

    always #5 clk = ~clk;

    wb_regfile #(.DW(32), .AW(5), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .w_pc(w_pc), .w_instr(w_instr), .w_data(w_data),
        .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
        .d_rs_data(d_rs_data), .d_rt_data(d_rt_data),
        .w_we(w_we), .w_dst(w_dst), .retire_cnt(retire_cnt)
    );

    // Narrow-counter instance for wrap-around behaviour.
    wb_regfile #(.DW(32), .AW(5), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .w_pc(w_pc), .w_instr(w_instr), .w_data(w_data),
        .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
        .d_rs_data(d4_rs_data), .d_rt_data(d4_rt_data),
        .w_we(w4_we), .w_dst(w4_dst), .retire_cnt(retire_cnt4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Which instructions write, and where.
    function automatic void ref_decode(input logic [31:0] ins, output bit we, output int dst);
        int op, fn;
        op  = int'(ins[31:26]);
        fn  = int'(ins[5:0]);
        we  = 1'b0;
        dst = 0;
        if (op == 0 && (fn == 32 || fn == 34)) begin
            we = 1'b1; dst = int'(ins[15:11]);
        end else if (op == 13 || op == 35 || op == 15) begin
            we = 1'b1; dst = int'(ins[20:16]);
        end else if (op == 3) begin
            we = 1'b1; dst = 31;
        end
    endfunction

    function automatic logic [31:0] ref_read(input int a, input bit we, input int dst,
                                             input logic [31:0] dat);
        if (a == 0) return 32'd0;
        if (we && dst == a) return dat;
        return m_gpr[a];
    endfunction

    // One W-stage cycle: drive, check combinational and registered outputs, update model.
    task automatic cycle(input logic [31:0] ins, input logic [31:0] dat,
                         input int ra, input int rb, input bit rst);
        bit we;
        int dst;
        @(negedge clk);
        reset     = rst;
        w_instr   = ins;
        w_data    = dat;
        w_pc      = pc;
        d_rs_addr = 5'(ra);
        d_rt_addr = 5'(rb);
        pc        = pc + 32'd4;
        #1;
        ref_decode(ins, we, dst);
        check("w_we",        {63'd0, w_we},        {63'd0, we});
        if (we) check("w_dst", {59'd0, w_dst},     64'(dst));
        check("d_rs_data",   {32'd0, d_rs_data},   {32'd0, ref_read(ra, we, dst, dat)});
        check("d_rt_data",   {32'd0, d_rt_data},   {32'd0, ref_read(rb, we, dst, dat)});
        check("retire_cnt",  {32'd0, retire_cnt},  {32'd0, m_cnt});
        check("retire_cnt4", {60'd0, retire_cnt4}, {60'd0, m_cnt[3:0]});
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
            m_cnt = 32'd0;
        end else begin
            if (we && dst != 0) m_gpr[dst] = dat;
            if (ins != 32'd0) m_cnt = m_cnt + 32'd1;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        rs  = 5'($urandom);
        rt  = 5'($urandom);
        rd  = 5'($urandom);
        imm = 16'($urandom);
        case ($urandom_range(0, 10))
            0:  return {6'h00, rs, rt, rd, 5'd0, 6'h20};
            1:  return {6'h00, rs, rt, rd, 5'd0, 6'h22};
            2:  return {6'h0D, rs, rt, imm};
            3:  return {6'h23, rs, rt, imm};
            4:  return {6'h0F, 5'd0, rt, imm};
            5:  return {6'h03, 26'($urandom)};
            6:  return {6'h2B, rs, rt, imm};
            7:  return {6'h04, rs, rt, imm};
            8:  return {6'h00, rs, 15'd0, 6'h08};
            9:  return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        pc        = 32'h0000_3000;
        m_cnt     = 32'd0;
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
        reset     = 1'b1;
        w_instr   = 32'd0;
        w_data    = 32'd0;
        w_pc      = 32'd0;
        d_rs_addr = 5'd0;
        d_rt_addr = 5'd0;
        @(posedge clk);

        // Reset cycle, then all registers read zero.
        cycle(32'd0, 32'd0, 0, 0, 1'b1);
        for (int i = 1; i < 32; i++) cycle(32'd0, 32'd0, i, 32 - i, 1'b0);

        // ori $5 with bypass, then from the array.
        cycle(32'h3405_0123, 32'h0000_0123, 5, 0, 1'b0);
        cycle(32'd0, 32'd0, 5, 5, 1'b0);
        // add $3 on both ports at once.
        cycle({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'h0000_DEAD, 3, 3, 1'b0);
        cycle(32'd0, 32'd0, 3, 5, 1'b0);
        // jal writes $31.
        cycle(32'h0C00_0C02, 32'h0000_3008, 31, 0, 1'b0);
        cycle(32'd0, 32'd0, 31, 31, 1'b0);
        // Write to $0 is discarded.
        cycle({6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20}, 32'hFFFF_FFFF, 0, 0, 1'b0);
        cycle(32'd0, 32'd0, 0, 3, 1'b0);
        // sw / beq / nop do not write; sw and beq retire.
        cycle(32'hAC07_0004, 32'h1111_1111, 7, 2, 1'b0);
        cycle(32'h1022_0003, 32'h2222_2222, 2, 7, 1'b0);
        cycle(32'd0,         32'h3333_3333, 7, 2, 1'b0);
        // lw $7 under reset is dropped.
        cycle(32'h8C07_0000, 32'h7777_7777, 7, 7, 1'b1);
        cycle(32'd0, 32'd0, 7, 5, 1'b0);
        // 16 retires from zero wrap the 4-bit counter back to 0.
        for (int i = 0; i < 16; i++) cycle(32'hAC00_0000, 32'd0, 0, 0, 1'b0);
        cycle(32'd0, 32'd0, 0, 0, 1'b0);

        // Randomized stream with frequent bypass hits and occasional reset.
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ins;
            bit we;
            int dst, ra, rb;
            ins = rand_instr();
            ref_decode(ins, we, dst);
            ra = $urandom_range(0, 31);
            rb = $urandom_range(0, 31);
            if ($urandom_range(0, 2) == 0) ra = dst;
            if ($urandom_range(0, 2) == 0) rb = dst;
            cycle(ins, $urandom, ra, rb, ($urandom_range(0, 59) == 0));
        end
        cycle(32'd0, 32'd0, 1, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
